// File: rtl/calc_sequencer.sv
// calc_sequencer: control block for the 4-bit switch calculator.
//   Synchronizes and debounces the operand buttons and operation keys,
//   captures operands from the active-low switch bank, issues operations
//   to the ALU over a start/done handshake, and latches the result.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_number[3:0]     operand switches, active-low
//   key[1:0]           load buttons, active-low (1: A, 0: B)
//   arif[3:0]          operation keys, active-low (4'b1111 = none)
//   alu_done           one-cycle completion pulse, alu_result valid with it
//   alu_result[10:0]   ALU result
//   reg_a, reg_b       operands to the ALU
//   alu_op, alu_start  operation code and one-cycle issue pulse
//   ind                last entered operand
//   result             latched ALU result
//   disp_sel           0 = show ind, 1 = show result
//   led[2:0]           active-low {error, B valid, A valid}
//   err                sticky timeout flag

// Single-bit debouncer: q follows d only after d has differed from q
// for DB_CYCLES consecutive cycles. Resets to the released level (1).
module cdb_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= 1'b1;
      cnt <= '0;
    end else if (d != q) begin
      if (cnt == CW'(DB_CYCLES - 1)) begin
        q   <= d;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
endmodule

module calc_sequencer #(
  parameter int DB_CYCLES = 50000,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in_number,
  input  logic [1:0]  key,
  input  logic [3:0]  arif,
  input  logic        alu_done,
  input  logic [10:0] alu_result,
  output logic [3:0]  reg_a,
  output logic [3:0]  reg_b,
  output logic [1:0]  alu_op,
  output logic        alu_start,
  output logic [3:0]  ind,
  output logic [10:0] result,
  output logic        disp_sel,
  output logic [2:0]  led,
  output logic        err
);
  localparam int NUM_BTN = 6;  // {key[1:0], arif[3:0]}
  localparam int TW      = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ENTRY, ISSUE, WAIT, SHOW} state_t;

  // 2-FF synchronizers; buttons reset to released
  logic [3:0]         num_s1, num_s2;
  logic [NUM_BTN-1:0] btn_s1, btn_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      num_s1 <= '1;
      num_s2 <= '1;
      btn_s1 <= '1;
      btn_s2 <= '1;
    end else begin
      num_s1 <= in_number;
      num_s2 <= num_s1;
      btn_s1 <= {key, arif};
      btn_s2 <= btn_s1;
    end
  end

  // per-bit debouncers
  logic [NUM_BTN-1:0] btn_db, btn_db_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    cdb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .d   (btn_s2[i]),
      .q   (btn_db[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) btn_db_q <= '1;
    else     btn_db_q <= btn_db;
  end

  // event detection on debounced levels
  logic [3:0] num;
  logic       load_a, load_b, load_ev;
  logic       op_hit, op_ev;
  logic [1:0] op_code;

  assign num    = ~num_s2;
  assign load_a = btn_db_q[5] & ~btn_db[5];
  assign load_b = btn_db_q[4] & ~btn_db[4];
  assign load_ev = load_a | load_b;

  always_comb begin
    op_hit  = 1'b0;
    op_code = 2'd0;
    case (btn_db[3:0])
      4'b1110: begin op_hit = 1'b1; op_code = 2'd0; end
      4'b1101: begin op_hit = 1'b1; op_code = 2'd1; end
      4'b1011: begin op_hit = 1'b1; op_code = 2'd2; end
      4'b0111: begin op_hit = 1'b1; op_code = 2'd3; end
      default: ;
    endcase
  end

  // only a transition out of "no key" counts, so a held or multi-key
  // pattern cannot fire again until everything is released
  assign op_ev = (btn_db_q[3:0] == 4'b1111) && op_hit;

  // state and datapath registers
  state_t        state, state_d;
  logic          va, vb, va_d, vb_d;
  logic [3:0]    a_d, b_d, ind_d;
  logic [10:0]   res_d;
  logic [1:0]    op_d;
  logic          disp_d, err_d, start_d;
  logic [TW-1:0] tcnt, tcnt_d;

  always_ff @(posedge clk) begin
    if (rst) state <= ENTRY;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    a_d     = reg_a;
    b_d     = reg_b;
    ind_d   = ind;
    va_d    = va;
    vb_d    = vb;
    res_d   = result;
    op_d    = alu_op;
    disp_d  = disp_sel;
    err_d   = err;
    tcnt_d  = tcnt;

    // loads are only taken while not busy; a load always wins over an op
    if (load_ev && (state == ENTRY || state == SHOW)) begin
      if (load_a) begin a_d = num; va_d = 1'b1; end
      if (load_b) begin b_d = num; vb_d = 1'b1; end
      ind_d   = num;
      disp_d  = 1'b0;
      state_d = ENTRY;
    end

    case (state)
      ENTRY: if (!load_ev && op_ev && va && vb) begin
        state_d = ISSUE;
        op_d    = op_code;
      end
      ISSUE: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        // tcnt holds completed WAIT cycles; done on the final cycle wins
        if (alu_done) begin
          res_d   = alu_result;
          disp_d  = 1'b1;
          err_d   = 1'b0;
          state_d = SHOW;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ENTRY;
        end else begin
          tcnt_d = tcnt + 1'b1;
        end
      end
      SHOW: if (!load_ev && op_ev) begin
        state_d = ISSUE;
        op_d    = op_code;
      end
      default: state_d = ENTRY;
    endcase

    start_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a     <= '0;
      reg_b     <= '0;
      ind       <= '0;
      va        <= 1'b0;
      vb        <= 1'b0;
      result    <= '0;
      alu_op    <= '0;
      disp_sel  <= 1'b0;
      err       <= 1'b0;
      alu_start <= 1'b0;
      led       <= 3'b111;
      tcnt      <= '0;
    end else begin
      reg_a     <= a_d;
      reg_b     <= b_d;
      ind       <= ind_d;
      va        <= va_d;
      vb        <= vb_d;
      result    <= res_d;
      alu_op    <= op_d;
      disp_sel  <= disp_d;
      err       <= err_d;
      alu_start <= start_d;
      led       <= {~err_d, ~vb_d, ~va_d};
      tcnt      <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  localparam int DB = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_number;
  logic [1:0]  key;
  logic [3:0]  arif;
  logic        alu_done;
  logic [10:0] alu_result;
  logic [3:0]  reg_a, reg_b, ind;
  logic [1:0]  alu_op;
  logic        alu_start, disp_sel, err;
  logic [10:0] result;
  logic [2:0]  led;

  calc_sequencer #(.DB_CYCLES(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_number(in_number), .key(key), .arif(arif),
    .alu_done(alu_done), .alu_result(alu_result), .reg_a(reg_a), .reg_b(reg_b),
    .alu_op(alu_op), .alu_start(alu_start), .ind(ind), .result(result),
    .disp_sel(disp_sel), .led(led), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int s0;
  bit ok;

  always @(posedge clk) if (alu_start) start_cnt <= start_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // press and release load button(s) with operand v on the switches
  task automatic load(input logic [1:0] k, input logic [3:0] v);
    in_number = ~v;
    cyc(1);
    key = k;
    cyc(10);
    key = 2'b11;
    cyc(10);
  endtask

  task automatic wait_start();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (alu_start) begin ok = 1'b1; break; end
      cyc(1);
    end
    chk("start_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic done_pulse(input logic [10:0] r);
    cyc(2);
    alu_done = 1'b1;
    alu_result = r;
    cyc(1);
    alu_done = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, reg_a, 0);
    chk({tag, "_b"}, reg_b, 0);
    chk({tag, "_ind"}, ind, 0);
    chk({tag, "_res"}, result, 0);
    chk({tag, "_op"}, alu_op, 0);
    chk({tag, "_start"}, alu_start, 0);
    chk({tag, "_disp"}, disp_sel, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_led"}, led, 3'b111);
  endtask

  initial begin
    rst = 1'b1; in_number = 4'hF; key = 2'b11; arif = 4'hF;
    alu_done = 1'b0; alu_result = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk_reset("rst");
    cyc(100);
    chk("idle_starts", start_cnt, 0);
    chk("idle_led", led, 3'b111);

    // basic add 3 + 5
    load(2'b01, 4'd3);
    chk("ldA_a", reg_a, 3);
    chk("ldA_ind", ind, 3);
    chk("ldA_led", led, 3'b110);
    load(2'b10, 4'd5);
    chk("ldB_b", reg_b, 5);
    chk("ldB_ind", ind, 5);
    chk("ldB_led", led, 3'b100);
    s0 = start_cnt;
    arif = 4'b1110;
    wait_start();
    chk("add_op", alu_op, 0);
    chk("add_a", reg_a, 3);
    chk("add_b", reg_b, 5);
    done_pulse(11'd8);
    chk("add_res", result, 8);
    chk("add_disp", disp_sel, 1);
    chk("add_err", err, 0);
    arif = 4'hF;
    cyc(10);
    chk("add_one_start", start_cnt, s0 + 1);

    // bounce rejection on key[1]
    in_number = ~4'd7;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      key = 2'b01; cyc(2);
      key = 2'b11; cyc(2);
    end
    key = 2'b11;
    cyc(10);
    chk("bounce_a", reg_a, 3);
    chk("bounce_ind", ind, 5);
    chk("bounce_disp", disp_sel, 1);

    // op without both operands, then non-one-hot op
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    load(2'b01, 4'd2);
    s0 = start_cnt;
    arif = 4'b1011; cyc(12); arif = 4'hF; cyc(10);
    chk("noB_start", start_cnt, s0);
    chk("noB_op", alu_op, 0);
    load(2'b10, 4'd6);
    chk("noB_led", led, 3'b100);
    arif = 4'b0011; cyc(12); arif = 4'hF; cyc(10);
    chk("multi_start", start_cnt, s0);

    // timeout
    arif = 4'b1011;
    wait_start();
    chk("to_op", alu_op, 2);
    cyc(TO);
    chk("to_err_pre", err, 0);
    cyc(1);
    chk("to_err", err, 1);
    chk("to_led", led, 3'b000);
    chk("to_res", result, 0);
    chk("to_disp", disp_sel, 0);
    arif = 4'hF;
    cyc(10);
    chk("to_starts", start_cnt, s0 + 1);
    load(2'b01, 4'd4);
    chk("to_ldA", reg_a, 4);
    chk("to_led2", led, 3'b000);
    arif = 4'b0111;
    wait_start();
    chk("div_op", alu_op, 3);
    done_pulse(11'h5A5);
    chk("div_res", result, 11'h5A5);
    chk("div_err", err, 0);
    chk("div_led", led, 3'b100);
    arif = 4'hF;
    cyc(10);

    // re-issue from SHOW with same operands
    arif = 4'b1101;
    wait_start();
    chk("re_op", alu_op, 1);
    chk("re_a", reg_a, 4);
    chk("re_b", reg_b, 6);
    done_pulse(11'h3FE);
    chk("re_res", result, 11'h3FE);
    chk("re_disp", disp_sel, 1);
    arif = 4'hF;
    cyc(10);

    // load and op events in the same cycle
    s0 = start_cnt;
    in_number = ~4'd9;
    cyc(1);
    key = 2'b10; arif = 4'b1110;
    cyc(12);
    chk("col_b", reg_b, 9);
    chk("col_ind", ind, 9);
    chk("col_a", reg_a, 4);
    chk("col_disp", disp_sel, 0);
    key = 2'b11; arif = 4'hF;
    cyc(10);
    chk("col_start", start_cnt, s0);
    chk("col_op", alu_op, 1);

    // both load buttons together
    load(2'b00, 4'hC);
    chk("both_a", reg_a, 4'hC);
    chk("both_b", reg_b, 4'hC);

    // reset during WAIT
    arif = 4'b1110;
    wait_start();
    cyc(2);
    rst = 1'b1; arif = 4'hF;
    cyc(1);
    chk_reset("wrst");
    s0 = start_cnt;
    rst = 1'b0;
    cyc(30);
    chk("wrst_nostart", start_cnt, s0);
    chk("wrst_led", led, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
